// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD word adder with start/done handshake, one digit per clock, LSD first.
// Optional macro BCD_SUB_EN adds a 'sub' port that nines-complements B for ten's-complement subtraction.
module bcd_serial_adder_ctrl #(
    parameter int DIGIT_NUM = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
`ifdef BCD_SUB_EN
    input  logic                     sub,
`endif
    input  logic [4*DIGIT_NUM-1:0]   A,
    input  logic [4*DIGIT_NUM-1:0]   B,
    input  logic                     Cin,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [4*DIGIT_NUM-1:0]   S,
    output logic                     Cout,
    output logic                     err
);

    localparam int W     = 4 * DIGIT_NUM;
    localparam int CNT_W = $clog2(DIGIT_NUM);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGIT_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [W-1:0]       a_sr_r, b_sr_r, s_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r, cout_r, err_r;
    logic               ready_r, busy_r, done_r;
    logic               accept_s, last_s, dig_bad_s;
    logic [3:0]         b_eff_s;
    logic [4:0]         dsum_s;
`ifdef BCD_SUB_EN
    logic               sub_r;
`endif

    // One BCD digit add; returns {carry_out, result_digit}. Out-of-range inputs follow the same rule.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] raw;
        logic [4:0] adj;
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, c};
        adj = raw + 5'd6;
        if (raw > 5'd9) begin
            bcd_digit_add = {1'b1, adj[3:0]};
        end else begin
            bcd_digit_add = {1'b0, raw[3:0]};
        end
    endfunction

    // Current digit datapath: operand selection, digit add and invalid-digit detection.
    always_comb begin
        b_eff_s = b_sr_r[3:0];
`ifdef BCD_SUB_EN
        if (sub_r) begin
            b_eff_s = 4'd9 - b_sr_r[3:0];
        end else begin
            b_eff_s = b_sr_r[3:0];
        end
`endif
        dsum_s    = bcd_digit_add(a_sr_r[3:0], b_eff_s, carry_r);
        dig_bad_s = (a_sr_r[3:0] > 4'd9) || (b_sr_r[3:0] > 4'd9);
        accept_s  = (state_r == ST_IDLE) && start;
        last_s    = (state_r == ST_RUN) && (cnt_r == LAST_CNT);
    end

    // Next-state logic; any unencoded state falls back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake outputs, decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    // Operand capture on accept, then one digit shifted through per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r  <= {W{1'b0}};
            b_sr_r  <= {W{1'b0}};
            s_r     <= {W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            err_r   <= 1'b0;
`ifdef BCD_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            a_sr_r  <= A;
            b_sr_r  <= B;
            carry_r <= Cin;
            cnt_r   <= {CNT_W{1'b0}};
            err_r   <= 1'b0;
`ifdef BCD_SUB_EN
            sub_r   <= sub;
`endif
        end else if (state_r == ST_RUN) begin
            a_sr_r  <= {4'h0, a_sr_r[W-1:4]};
            b_sr_r  <= {4'h0, b_sr_r[W-1:4]};
            s_r     <= {dsum_s[3:0], s_r[W-1:4]};
            carry_r <= dsum_s[4];
            cnt_r   <= cnt_r + CNT_W'(1);
            err_r   <= err_r | dig_bad_s;
            if (last_s) begin
                cout_r <= dsum_s[4];
            end else begin
                cout_r <= cout_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign S     = s_r;
    assign Cout  = cout_r;
    assign err   = err_r;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl: directed test-plan vectors plus randomized runs
// against a decimal-arithmetic reference model. Subtraction cases build only with BCD_SUB_EN.
module tb_bcd_serial_adder_ctrl;

    localparam int N = 8;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub_i;
    logic [W-1:0] A, B;
    logic         Cin;
    logic         ready, busy, done, Cout, err;
    logic [W-1:0] S;

    int n_cmp = 0;
    int n_err = 0;

    bcd_serial_adder_ctrl #(.DIGIT_NUM(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef BCD_SUB_EN
        .sub   (sub_i),
`endif
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal arithmetic for valid operands, per-digit rule when any digit is >9.
    function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                      input logic sub, output logic [W-1:0] s, output logic cout,
                                      output logic e);
        bit     bad = 0;
        longint va = 0, vb = 0, p = 1, sum, full;
        int     c, raw, an, bn;
        for (int i = 0; i < N; i++) begin
            an = int'(a[4*i +: 4]);
            bn = int'(b[4*i +: 4]);
            if (an > 9 || bn > 9) bad = 1;
        end
        e = bad;
        s = '0;
        if (!bad) begin
            for (int i = 0; i < N; i++) begin
                va += longint'(a[4*i +: 4]) * p;
                vb += longint'(b[4*i +: 4]) * p;
                p  *= 10;
            end
            full = p;
            if (sub) vb = (full - 1) - vb;
            sum  = va + vb + longint'(cin);
            cout = (sum >= full);
            sum  = sum % full;
            for (int i = 0; i < N; i++) begin
                s[4*i +: 4] = 4'(sum % 10);
                sum = sum / 10;
            end
        end else begin
            c = int'(cin);
            for (int i = 0; i < N; i++) begin
                an = int'(a[4*i +: 4]);
                bn = int'(b[4*i +: 4]);
                if (sub) bn = (9 - bn) & 15;
                raw = an + bn + c;
                if (raw > 9) begin
                    s[4*i +: 4] = 4'((raw + 6) % 16);
                    c = 1;
                end else begin
                    s[4*i +: 4] = 4'(raw);
                    c = 0;
                end
            end
            cout = c[0];
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 3) == 0)) v[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // One operation: wait for ready at a negedge, pulse start, optionally inject a start at RUN cycle inj.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input int inj);
        logic [W-1:0] es;
        logic         ec, ee;
        int           k;
        bit           got;
        k = 0;
        while (ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_val("ready_idle", 64'(ready), 64'd1);
        ref_model(a, b, cin, sub, es, ec, ee);
        A = a; B = b; Cin = cin; sub_i = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = rand_bcd(1'b0); B = rand_bcd(1'b0); Cin = ~cin; sub_i = ~sub;
        check_val("busy_run", {62'd0, busy, ready}, 64'd2);
        got = 0;
        for (k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            if (k == inj) begin
                start = 1'b1; A = rand_bcd(1'b1); B = rand_bcd(1'b1); Cin = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        start = 1'b0;
        if (!got) begin
            check_val("done_timeout", 64'd0, 64'd1);
        end else begin
            check_val("latency", 64'(k), 64'(N));
            check_val("sum", 64'(S), 64'(es));
            check_val("cout", 64'(Cout), 64'(ec));
            check_val("err", 64'(err), 64'(ee));
        end
        @(negedge clk);
        check_val("done_pulse", 64'(done), 64'd0);
        check_val("s_hold", 64'(S), 64'(es));
        check_val("cout_hold", 64'(Cout), 64'(ec));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub_i = 1'b0; A = '0; B = '0; Cin = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_outs", {58'd0, ready, busy, done, Cout, err, 1'b0}, 64'h20);
        check_val("rst_s", 64'(S), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h12345678, 32'h87654321, 1'b0, 1'b0, 0);
        check_val("tp_basic", {31'd0, Cout, S}, {31'd0, 1'b0, 32'h99999999});
        run_op(32'h99999999, 32'h00000001, 1'b0, 1'b0, 0);
        check_val("tp_ripple", {31'd0, Cout, S}, {31'd0, 1'b1, 32'h00000000});
        run_op(32'h99999999, 32'h99999999, 1'b1, 1'b0, 0);
        check_val("tp_max", {31'd0, Cout, S}, {31'd0, 1'b1, 32'h99999999});
        run_op(32'h00001234, 32'h00005678, 1'b0, 1'b0, 3);
        check_val("tp_ignore", {31'd0, Cout, S}, {31'd0, 1'b0, 32'h00006912});
        run_op(32'h99999999, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(32'h00000000, 32'h00000000, 1'b0, 1'b0, 0);
        check_val("tp_stale", {31'd0, Cout, S}, 64'd0);
        run_op(32'h0000000A, 32'h00000000, 1'b0, 1'b0, 0);
        check_val("tp_bad", {30'd0, err, Cout, S}, {30'd0, 1'b1, 1'b0, 32'h00000010});
        run_op(32'h00000011, 32'h00000022, 1'b0, 1'b0, 0);
        check_val("tp_err_clr", {30'd0, err, Cout, S}, {30'd0, 1'b0, 1'b0, 32'h00000033});

        // Abort mid-run: outputs go to reset values and no done follows.
        A = 32'h55555555; B = 32'h55555555; Cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("abort_outs", {58'd0, ready, busy, done, Cout, err, 1'b0}, 64'h20);
        check_val("abort_s", 64'(S), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("abort_nodone", 64'(done), 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check_val("post_abort_idle", {62'd0, done, ready}, 64'd1);
        end
        run_op(32'h00004321, 32'h00001234, 1'b1, 1'b0, 0);
        check_val("tp_fresh", {31'd0, Cout, S}, {31'd0, 1'b0, 32'h00005556});

        for (int i = 0; i < 30; i++) begin
            run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)), 1'b0,
                   (i % 4 == 0) ? int'($urandom_range(1, N - 1)) : 0);
        end

`ifdef BCD_SUB_EN
        run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0);
        check_val("tp_sub_neg", {31'd0, Cout, S}, {31'd0, 1'b0, 32'h99999998});
        run_op(32'h00000007, 32'h00000005, 1'b1, 1'b1, 0);
        check_val("tp_sub_pos", {31'd0, Cout, S}, {31'd0, 1'b1, 32'h00000002});
        for (int i = 0; i < 15; i++) begin
            run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)), 1'b1, 0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
